reflet_bus_arbiter: RTL and testbench
=====================================

// Module: reflet_bus_arbiter
// PURPOSE
// - Shares the single system memory bus (instruction ROM, data RAM, peripherals) between two masters.
//   - m0: the reflet_cpu.
//   - m1: a secondary master, e.g. a DMA or debug engine.
// - Sits between the masters and the address-decoded slaves; drives the shared addr/data_out/write_en.
// - Produces a per-master stall signal; m0_stall feeds the CPU enable (cpu_enable = !m0_stall & power enable).
// - Round-robin arbitration with a bounded burst length, so neither master starves the other.
// PARAMETERS
// - wordsize   16  width of address and data buses
// - max_burst  4   consecutive granted cycles before a forced handover when the other master waits;
//                  0 = unlimited (owner keeps the bus until it drops req)
// PORTS
// - clk          in   1         system clock
// - reset        in   1         synchronous, active-high reset
// - m0_req       in   1         master 0 requests the bus this cycle
// - m0_addr      in   wordsize  master 0 address
// - m0_wdata     in   wordsize  master 0 write data
// - m0_we        in   1         master 0 write enable
// - m0_gnt       out  1         master 0 owns the bus (registered)
// - m0_stall     out  1         m0_req & !m0_gnt (combinational)
// - m0_rvalid    out  1         read data for master 0 is valid on rdata this cycle
// - m1_req/m1_addr/m1_wdata/m1_we/m1_gnt/m1_stall/m1_rvalid   same as m0, for master 1
// - rdata        out  wordsize  bus read data, broadcast to both masters (= bus_rdata)
// - bus_addr     out  wordsize  shared address to slaves
// - bus_wdata    out  wordsize  shared write data to slaves
// - bus_we       out  1         shared write enable to slaves
// - bus_rdata    in   wordsize  OR of slave read data (one-cycle latency, registered slaves)
// BEHAVIOUR
// - States: IDLE, OWN0, OWN1.
//   - m0_gnt = (state==OWN0); m1_gnt = (state==OWN1).
// - Registers: last (last owner, 1 bit); cnt (burst counter, saturating, width clog2(max_burst+1), min 1).
// - Reset: state=IDLE, last=1 (m0 wins the first tie), cnt=0, m*_rvalid=0.
//   - Outputs while in reset and in IDLE: bus_addr=0, bus_wdata=0, bus_we=0, gnts=0.
// - Access qualifier: acc_x = gnt_x & mx_req.
//   - Bus outputs come from the master with acc_x, else all zero.
//   - bus_we can never be 1 without an owning, requesting master.
// - IDLE transitions:
//   - only m0_req -> OWN0;  only m1_req -> OWN1
//   - both -> the master != last
//   - none -> stay IDLE
//   - The grant appears the cycle after req; the first access happens that cycle.
// - OWNx transitions (y = other master):
//   - mx_req=0: my_req -> OWNy, else -> IDLE.
//   - mx_req=1, my_req=1, max_burst!=0, cnt>=max_burst-1: -> OWNy (forced handover).
//   - otherwise: stay, cnt+1 (saturating).
//   - Handover goes straight OWNx->OWNy, with no idle cycle.
// - cnt: cleared on every entry into OWN0/OWN1. last is updated to x on entry into OWNx.
// - Reads:
//   - mx_rvalid is registered: mx_rvalid(t+1) = acc_x(t) & !mx_we(t).
//   - rdata = bus_rdata, sampled by the master when its rvalid is high.
//   - Data for the last access before a handover still returns to the old owner one cycle later.
//   - The new owner's first access overlaps that return; there is no conflict, since rvalid is per master.
// - Writes: complete in the cycle acc_x is high; no response.
// - Simultaneous events:
//   - A req rising in the same cycle as the owner drops req is granted next cycle.
//   - With both reqs falling, -> IDLE.
// - Reset mid-burst: the grant and rvalid drop on the reset edge; an in-flight read is discarded.
// TESTING
// - Reset, then m0_req=1 alone, addr 0x0010 read
//   -> m0_gnt=1 in cycle 1, bus_addr=0x0010, m0_rvalid=1 in cycle 2 with rdata=bus_rdata.
// - Both req raised in the same cycle from IDLE after reset
//   -> m0 granted first; after m0 drops req, m1 granted next cycle; on a fresh tie, m0 granted again.
// - max_burst=4, m0_req held, m1_req raised
//   -> m0 owns exactly 4 cycles, then m1_gnt=1; m0_stall=1 while m1 owns.
// - m1 write 0xBEEF to 0xFF10, m0_req=0 -> bus_we=1 for one cycle with bus_wdata=0xBEEF;
//   - m1_rvalid stays 0; bus_we=0 once m1_req drops.
// - Owner drops req with the other idle -> IDLE; bus_addr=0 and bus_we=0 while idle.
// - Assert reset during an m1 burst with a read in flight
//   -> next cycle m1_gnt=0, m1_rvalid=0, state IDLE; a subsequent tie goes to m0.

Source files
------------

// File: rtl/reflet_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reflet_bus_arbiter
//
// Shares the single system memory bus (ROM, RAM, peripherals) between two
// masters: m0 (the reflet CPU) and m1 (a secondary master such as DMA or a
// debug engine). Arbitration is round-robin. When both masters keep
// requesting, a bounded burst length forces the bus to be handed over.
//
// Handshake: a master holds mx_req high for every cycle in which it wants a
// bus access. An access happens in every cycle where mx_gnt and mx_req are
// both high (acc_x). mx_gnt is registered, so it appears the cycle after the
// request is first seen. mx_stall = mx_req & !mx_gnt tells the master to hold
// its request and address. For reads, mx_rvalid goes high exactly one cycle
// after the access, and rdata is valid in that cycle.
//
// Parameters
//   wordsize   width of address and data buses
//   max_burst  consecutive owned cycles before a forced handover while the
//              other master waits; 0 = owner keeps the bus until it drops req
//
// Ports
//   clk, reset                   system clock, synchronous active-high reset
//   mx_req/addr/wdata/we         master x request, address, write data, write enable
//   mx_gnt                       master x owns the bus (registered)
//   mx_stall                     master x requests but does not own the bus
//   mx_rvalid                    read data for master x is on rdata this cycle
//   rdata                        bus read data broadcast to both masters
//   bus_addr/bus_wdata/bus_we    shared slave-side outputs (zero when no access)
//   bus_rdata                    OR of slave read data, one-cycle latency
//   dbg_state                    arbiter state (0 IDLE, 1 OWN0, 2 OWN1)
// -----------------------------------------------------------------------------
module reflet_bus_arbiter #(
  parameter int wordsize  = 16,
  parameter int max_burst = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_wdata,
  input  logic                m0_we,
  output logic                m0_gnt,
  output logic                m0_stall,
  output logic                m0_rvalid,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_wdata,
  input  logic                m1_we,
  output logic                m1_gnt,
  output logic                m1_stall,
  output logic                m1_rvalid,
  output logic [wordsize-1:0] rdata,
  output logic [wordsize-1:0] bus_addr,
  output logic [wordsize-1:0] bus_wdata,
  output logic                bus_we,
  input  logic [wordsize-1:0] bus_rdata,
  output logic [1:0]          dbg_state
);

  // The counter needs to reach max_burst-1. Keep it at least one bit wide.
  localparam int CW = (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  localparam int BL = (max_burst == 0) ? 0 : max_burst - 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BL);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            last;        // last owner: 0 = m0, 1 = m1
  logic [CW-1:0]   cnt;         // owned cycles since entry, saturating
  logic            burst_done;
  logic            acc0;
  logic            acc1;

  // The owner has used its burst allowance. With max_burst = 0 it never runs out.
  assign burst_done = (max_burst != 0) && (cnt >= BURST_LAST);

  // State register, last owner, burst counter and read-return flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;        // makes m0 win the first tie
      cnt       <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      state     <= state_next;
      m0_rvalid <= acc0 & ~m0_we;
      m1_rvalid <= acc1 & ~m1_we;
      if (state_next == OWN0 && state != OWN0) begin
        last <= 1'b0;
        cnt  <= '0;
      end else if (state_next == OWN1 && state != OWN1) begin
        last <= 1'b1;
        cnt  <= '0;
      end else if (state != IDLE && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_next = last ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_next = OWN0;
        end else if (m1_req) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          state_next = m1_req ? OWN1 : IDLE;
        end else if (m1_req && burst_done) begin
          state_next = OWN1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_next = m0_req ? OWN0 : IDLE;
        end else if (m0_req && burst_done) begin
          state_next = OWN0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: bus outputs follow the master that is actually accessing.
  // With no access they are all zero, so bus_we can never be high without
  // an owning, requesting master.
  always_comb begin
    m0_gnt    = (state == OWN0);
    m1_gnt    = (state == OWN1);
    acc0      = m0_gnt & m0_req;
    acc1      = m1_gnt & m1_req;
    m0_stall  = m0_req & ~m0_gnt;
    m1_stall  = m1_req & ~m1_gnt;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    if (acc0) begin
      bus_addr  = m0_addr;
      bus_wdata = m0_wdata;
      bus_we    = m0_we;
    end else if (acc1) begin
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
      bus_we    = m1_we;
    end
    rdata     = bus_rdata;
    dbg_state = state;
  end

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reflet_bus_arbiter
//
// Directed cycle-by-cycle vectors for reflet_bus_arbiter (wordsize 16,
// max_burst 4). Each step drives one cycle of master inputs and pushes the
// hand-computed outputs for that cycle. A monitor on the falling edge pops
// and compares them. A registered slave model returns bus_addr ^ 0x5A5A one
// cycle after a read, so expected rdata values are addr ^ 0x5A5A.
// -----------------------------------------------------------------------------
module tb_reflet_bus_arbiter;

  localparam int W = 57;  // {state[2], ctl[7], addr[16], wdata[16], rdata[16]}
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_stall, m1_rvalid;
  logic [15:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic        bus_we;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  reflet_bus_arbiter #(.wordsize(16), .max_burst(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_stall(m1_stall), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Registered slave: read data appears one cycle after the access
  initial bus_rdata = 16'h0000;
  always @(posedge clk) bus_rdata <= bus_we ? 16'h0000 : (bus_addr ^ 16'h5A5A);

  // Driver: one call = one bus cycle. e_ctl = {g0, g1, s0, s1, rv0, rv1, we}
  task automatic step(input string nm, input logic rst,
                      input logic r0, input logic [15:0] a0, input logic w0, input logic [15:0] d0,
                      input logic r1, input logic [15:0] a1, input logic w1, input logic [15:0] d1,
                      input logic [1:0] e_st, input logic [6:0] e_ctl,
                      input logic [15:0] e_addr, input logic [15:0] e_wdata, input logic [15:0] e_rdata);
    @(posedge clk);
    #1;
    reset    = rst;
    m0_req   = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
    m1_req   = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    exp_q.push_back({e_st, e_ctl, e_addr, e_wdata, e_rdata});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  string        mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = {dbg_state, m0_gnt, m1_gnt, m0_stall, m1_stall, m0_rvalid, m1_rvalid,
                 bus_we, bus_addr, bus_wdata, rdata};
      // rdata only matters in a cycle where a read returns
      if (mon_exp[50:49] == 2'b00) mon_act[15:0] = mon_exp[15:0];
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: actual st=%0d ctl=%b addr=%h wdata=%h rdata=%h, required st=%0d ctl=%b addr=%h wdata=%h rdata=%h",
                 mon_nm, mon_act[56:55], mon_act[54:48], mon_act[47:32], mon_act[31:16], mon_act[15:0],
                 mon_exp[56:55], mon_exp[54:48], mon_exp[47:32], mon_exp[31:16], mon_exp[15:0]);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    reset  = 1'b1;
    m0_req = 1'b0; m0_addr = 16'h0; m0_we = 1'b0; m0_wdata = 16'h0;
    m1_req = 1'b0; m1_addr = 16'h0; m1_we = 1'b0; m1_wdata = 16'h0;
    repeat (2) @(posedge clk);

    // reset state, single m0 read of 0x0010
    step("reset_idle",  0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_IDLE, 7'b0000000, 16'h0000,16'h0000,16'h0000);
    step("m0_req_wait", 0, 1,16'h0010,0,16'h0, 0,16'h0000,0,16'h0, ST_IDLE, 7'b0010000, 16'h0000,16'h0000,16'h0000);
    step("m0_grant",    0, 1,16'h0010,0,16'h0, 0,16'h0000,0,16'h0, ST_OWN0, 7'b1000000, 16'h0010,16'h0000,16'h0000);
    step("m0_rvalid",   0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_OWN0, 7'b1000100, 16'h0000,16'h0000,16'h5A4A);
    step("drop_idle",   0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_IDLE, 7'b0000000, 16'h0000,16'h0000,16'h0000);

    // tie after reset -> m0, then m1 after m0 drops, fresh tie -> m0
    step("reset_row",   1, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_IDLE, 7'b0000000, 16'h0000,16'h0000,16'h0000);
    step("tie_wait",    0, 1,16'h0100,0,16'h0, 1,16'h0200,0,16'h0, ST_IDLE, 7'b0011000, 16'h0000,16'h0000,16'h0000);
    step("tie_m0",      0, 1,16'h0100,0,16'h0, 1,16'h0200,0,16'h0, ST_OWN0, 7'b1001000, 16'h0100,16'h0000,16'h0000);
    step("m0_drop",     0, 0,16'h0000,0,16'h0, 1,16'h0200,0,16'h0, ST_OWN0, 7'b1001100, 16'h0000,16'h0000,16'h5B5A);
    step("m1_next",     0, 0,16'h0000,0,16'h0, 1,16'h0200,0,16'h0, ST_OWN1, 7'b0100000, 16'h0200,16'h0000,16'h0000);
    step("m1_rvalid",   0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_OWN1, 7'b0100010, 16'h0000,16'h0000,16'h585A);
    step("tie2_wait",   0, 1,16'h0300,0,16'h0, 1,16'h0400,0,16'h0, ST_IDLE, 7'b0011000, 16'h0000,16'h0000,16'h0000);
    step("tie2_m0",     0, 1,16'h0300,0,16'h0, 1,16'h0400,0,16'h0, ST_OWN0, 7'b1001000, 16'h0300,16'h0000,16'h0000);

    // burst limit: m0 owns exactly 4 cycles, then m1 while m0 stalls
    step("burst_2",     0, 1,16'h0300,0,16'h0, 1,16'h0400,0,16'h0, ST_OWN0, 7'b1001100, 16'h0300,16'h0000,16'h595A);
    step("burst_3",     0, 1,16'h0300,0,16'h0, 1,16'h0400,0,16'h0, ST_OWN0, 7'b1001100, 16'h0300,16'h0000,16'h595A);
    step("burst_4",     0, 1,16'h0300,0,16'h0, 1,16'h0400,0,16'h0, ST_OWN0, 7'b1001100, 16'h0300,16'h0000,16'h595A);
    step("handover",    0, 1,16'h0300,0,16'h0, 1,16'h0400,0,16'h0, ST_OWN1, 7'b0110100, 16'h0400,16'h0000,16'h595A);
    step("m1_own_2",    0, 1,16'h0300,0,16'h0, 1,16'h0400,0,16'h0, ST_OWN1, 7'b0110010, 16'h0400,16'h0000,16'h5E5A);
    step("both_drop",   0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_OWN1, 7'b0100010, 16'h0000,16'h0000,16'h5E5A);
    step("idle_again",  0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_IDLE, 7'b0000000, 16'h0000,16'h0000,16'h0000);

    // m1 write 0xBEEF to 0xFF10
    step("m1_wr_wait",  0, 0,16'h0000,0,16'h0, 1,16'hFF10,1,16'hBEEF, ST_IDLE, 7'b0001000, 16'h0000,16'h0000,16'h0000);
    step("m1_write",    0, 0,16'h0000,0,16'h0, 1,16'hFF10,1,16'hBEEF, ST_OWN1, 7'b0100001, 16'hFF10,16'hBEEF,16'h0000);
    step("m1_wr_done",  0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0000, ST_OWN1, 7'b0100000, 16'h0000,16'h0000,16'h0000);
    step("wr_idle",     0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0000, ST_IDLE, 7'b0000000, 16'h0000,16'h0000,16'h0000);

    // reset during an m1 burst with a read in flight
    step("m1_rd_wait",  0, 0,16'h0000,0,16'h0, 1,16'h0500,0,16'h0, ST_IDLE, 7'b0001000, 16'h0000,16'h0000,16'h0000);
    step("m1_rd",       0, 0,16'h0000,0,16'h0, 1,16'h0500,0,16'h0, ST_OWN1, 7'b0100000, 16'h0500,16'h0000,16'h0000);
    step("reset_mid",   1, 0,16'h0000,0,16'h0, 1,16'h0502,0,16'h0, ST_OWN1, 7'b0100010, 16'h0502,16'h0000,16'h5F5A);
    step("after_reset", 0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_IDLE, 7'b0000000, 16'h0000,16'h0000,16'h0000);
    step("tie3_wait",   0, 1,16'h0600,0,16'h0, 1,16'h0700,0,16'h0, ST_IDLE, 7'b0011000, 16'h0000,16'h0000,16'h0000);
    step("tie3_m0",     0, 1,16'h0600,0,16'h0, 1,16'h0700,0,16'h0, ST_OWN0, 7'b1001000, 16'h0600,16'h0000,16'h0000);
    step("tie3_drop",   0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_OWN0, 7'b1000100, 16'h0000,16'h0000,16'h5C5A);
    step("final_idle",  0, 0,16'h0000,0,16'h0, 0,16'h0000,0,16'h0, ST_IDLE, 7'b0000000, 16'h0000,16'h0000,16'h0000);

    // let the monitor consume the last vector, then confirm nothing was left over
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
